// File: rtl/branch_inflight_tracker.sv
// rtl/branch_inflight_tracker.sv - per-tag tracker for unresolved branches between decode and the instruction queue
//
// Hands out one tag per branch lane of an accepted decode group, frees tags on
// resolve, squashes the resolving tag plus every younger tag on a mispredict,
// and stalls decode when the free tags cannot cover the whole group.
// Optional statistics outputs are built only when BRANCH_TRACKER_STATS_EN is defined.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   dec_valid_i           decode group valid
//   dec_branch_mask_i     per-lane branch flag, lane 0 oldest
//   iq_ready_i            instruction queue can take the whole group
//   dec_ready_o           group accepted this cycle
//   alloc_valid_o         lane received a tag
//   alloc_id_o            tag per lane, lane i at [i*ID_BITS +: ID_BITS]
//   resolve_valid_i       a branch resolved
//   resolve_id_i          tag being resolved
//   resolve_mispredict_i  resolution was a mispredict
//   flush_i               full pipeline flush
//   squash_mask_o         tags killed last cycle (one-cycle pulse)
//   inflight_cnt_o        number of occupied tags
//   stall_o               valid group blocked by tag shortage
//   stat_*_o              stall cycles, peak occupancy, mispredicts (stats build only)

module branch_inflight_tracker #(
    parameter int DECODE_WIDTH  = 2,
    parameter int MAX_BRANCH_IF = 4,
    parameter int ID_BITS       = $clog2(MAX_BRANCH_IF)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            dec_valid_i,
    input  logic [DECODE_WIDTH-1:0]         dec_branch_mask_i,
    input  logic                            iq_ready_i,
    output logic                            dec_ready_o,
    output logic [DECODE_WIDTH-1:0]         alloc_valid_o,
    output logic [DECODE_WIDTH*ID_BITS-1:0] alloc_id_o,
    input  logic                            resolve_valid_i,
    input  logic [ID_BITS-1:0]              resolve_id_i,
    input  logic                            resolve_mispredict_i,
    input  logic                            flush_i,
    output logic [MAX_BRANCH_IF-1:0]        squash_mask_o,
    output logic [ID_BITS:0]                inflight_cnt_o,
    output logic                            stall_o
`ifdef BRANCH_TRACKER_STATS_EN
    ,
    output logic [31:0]                     stat_stall_cycles_o,
    output logic [ID_BITS:0]                stat_peak_inflight_o,
    output logic [31:0]                     stat_mispredicts_o
`endif
);

    // Wide enough to hold both a full tag count and a full lane count.
    localparam int CW = ID_BITS + 3;

    logic [MAX_BRANCH_IF-1:0] busy_q;
    logic [MAX_BRANCH_IF-1:0] age_q [MAX_BRANCH_IF];

    logic [MAX_BRANCH_IF-1:0] busy_n;
    logic [MAX_BRANCH_IF-1:0] age_n [MAX_BRANCH_IF];
    logic [MAX_BRANCH_IF-1:0] squash_n;
    logic [ID_BITS:0]         busy_cnt_n;

    logic [MAX_BRANCH_IF-1:0] alloc_set;
    logic [MAX_BRANCH_IF-1:0] alloc_row [MAX_BRANCH_IF];
    logic [MAX_BRANCH_IF-1:0] kill;
    logic                     mis_hit;
    logic [CW-1:0]            need_cnt;
    logic [CW-1:0]            free_cnt;
    logic                     fire;

    function automatic logic [ID_BITS:0] pop_tags(input logic [MAX_BRANCH_IF-1:0] v);
        logic [ID_BITS:0] c;
        c = '0;
        for (int i = 0; i < MAX_BRANCH_IF; i++) begin
            c = c + (ID_BITS+1)'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [CW-1:0] pop_lanes(input logic [DECODE_WIDTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Free tags come from the registered bitmap only, so a tag released this
    // cycle is never handed out again before the next edge.
    assign need_cnt    = pop_lanes(dec_branch_mask_i);
    assign free_cnt    = CW'(MAX_BRANCH_IF) - CW'(pop_tags(busy_q));
    assign stall_o     = dec_valid_i & (need_cnt > free_cnt) & ~flush_i;
    assign dec_ready_o = iq_ready_i & ~stall_o & ~flush_i
                       & ~(resolve_valid_i & resolve_mispredict_i);
    assign fire        = dec_valid_i & dec_ready_o;

    // Lane-ordered allocation: each branch lane takes the lowest tag that is
    // neither busy nor already taken by an older lane of the same group. The
    // age row of a new tag is everything busy plus the older lanes' new tags.
    always_comb begin
        logic found;
        alloc_set     = '0;
        alloc_valid_o = '0;
        alloc_id_o    = '0;
        found         = 1'b0;
        for (int k = 0; k < MAX_BRANCH_IF; k++) begin
            alloc_row[k] = '0;
        end
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            found = 1'b0;
            if (fire && dec_branch_mask_i[i]) begin
                for (int k = 0; k < MAX_BRANCH_IF; k++) begin
                    if (!found && !busy_q[k] && !alloc_set[k]) begin
                        found                              = 1'b1;
                        alloc_row[k]                       = busy_q | alloc_set;
                        alloc_set[k]                       = 1'b1;
                        alloc_id_o[i*ID_BITS +: ID_BITS]   = ID_BITS'(k);
                        alloc_valid_o[i]                   = 1'b1;
                    end
                end
            end
        end
    end

    // Kill set for a mispredict: the resolving tag plus every busy tag whose
    // age row says the resolving tag is older than it.
    always_comb begin
        kill    = '0;
        mis_hit = resolve_valid_i & resolve_mispredict_i & busy_q[resolve_id_i];
        if (mis_hit) begin
            kill[resolve_id_i] = 1'b1;
            for (int j = 0; j < MAX_BRANCH_IF; j++) begin
                if (busy_q[j] && age_q[j][resolve_id_i]) begin
                    kill[j] = 1'b1;
                end
            end
        end
    end

    // A newly allocated tag is younger than every existing tag, so its column
    // is cleared in all other rows; stale bits from a previous owner of that
    // tag would otherwise make an older branch look younger.
    always_comb begin
        busy_n   = busy_q;
        squash_n = '0;
        for (int j = 0; j < MAX_BRANCH_IF; j++) begin
            age_n[j] = age_q[j];
        end
        if (flush_i) begin
            busy_n   = '0;
            squash_n = busy_q;
            for (int j = 0; j < MAX_BRANCH_IF; j++) begin
                age_n[j] = '0;
            end
        end else begin
            if (mis_hit) begin
                busy_n   = busy_n & ~kill;
                squash_n = kill;
            end else if (resolve_valid_i && !resolve_mispredict_i) begin
                busy_n[resolve_id_i] = 1'b0;
            end
            busy_n = busy_n | alloc_set;
            for (int j = 0; j < MAX_BRANCH_IF; j++) begin
                age_n[j] = alloc_set[j] ? alloc_row[j] : (age_q[j] & ~alloc_set);
            end
        end
        busy_cnt_n = pop_tags(busy_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q         <= '0;
            squash_mask_o  <= '0;
            inflight_cnt_o <= '0;
            for (int j = 0; j < MAX_BRANCH_IF; j++) begin
                age_q[j] <= '0;
            end
        end else begin
            busy_q         <= busy_n;
            squash_mask_o  <= squash_n;
            inflight_cnt_o <= busy_cnt_n;
            for (int j = 0; j < MAX_BRANCH_IF; j++) begin
                age_q[j] <= age_n[j];
            end
        end
    end

`ifdef BRANCH_TRACKER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_cycles_o  <= '0;
            stat_peak_inflight_o <= '0;
            stat_mispredicts_o   <= '0;
        end else begin
            if (stall_o && (stat_stall_cycles_o != '1)) begin
                stat_stall_cycles_o <= stat_stall_cycles_o + 32'd1;
            end
            if (busy_cnt_n > stat_peak_inflight_o) begin
                stat_peak_inflight_o <= busy_cnt_n;
            end
            if (!flush_i && mis_hit && (stat_mispredicts_o != '1)) begin
                stat_mispredicts_o <= stat_mispredicts_o + 32'd1;
            end
        end
    end
`endif

    resolve_busy_a: assert property (@(posedge clk) disable iff (!rst_n)
        (resolve_valid_i && !flush_i) |-> busy_q[resolve_id_i]);

endmodule

// File: doc/branch_inflight_tracker.md
Name: branch_inflight_tracker

Overview:
- Parametrised successor to the decode-stage scalar branch-in-flight counter; sits between instruction decode and the instruction queue.
- Tracks up to MAX_BRANCH_IF unresolved branches as individual tags (IDs) rather than a count.
- Allocates one tag per branch in a DECODE_WIDTH-wide decode group and releases tags on resolution.
- On a mispredict, squashes the resolving tag and every younger tag; stalls decode atomically when the free tags cannot cover the group.

Parameters:
- DECODE_WIDTH, 2, instructions per decode group (1..4).
- MAX_BRANCH_IF, 4, number of branch tags (2..16, power of two).
- ID_BITS, $clog2(MAX_BRANCH_IF), tag width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- dec_valid_i  in  1  decode group valid.
- dec_branch_mask_i  in  DECODE_WIDTH  per-lane "is branch"; lane 0 is oldest.
- iq_ready_i  in  1  instruction queue can accept the whole group.
- dec_ready_o  out  1  group accepted this cycle.
- alloc_valid_o  out  DECODE_WIDTH  lane received a tag (dec_branch_mask_i & fire).
- alloc_id_o  out  DECODE_WIDTH*ID_BITS  tag per lane; lane i in bits [i*ID_BITS +: ID_BITS].
- resolve_valid_i  in  1  a branch resolved.
- resolve_id_i  in  ID_BITS  tag being resolved.
- resolve_mispredict_i  in  1  resolution was a mispredict.
- flush_i  in  1  full pipeline flush.
- squash_mask_o  out  MAX_BRANCH_IF  tags killed this cycle (registered, one pulse).
- inflight_cnt_o  out  ID_BITS+1  number of occupied tags.
- stall_o  out  1  a valid group is blocked by tag shortage.

Behaviour:
- State:
  - busy[MAX_BRANCH_IF] occupancy bitmap.
  - age[MAX_BRANCH_IF][MAX_BRANCH_IF] matrix; age[j][k]=1 means tag k is older than tag j.
- need = popcount(dec_branch_mask_i); free = MAX_BRANCH_IF - popcount(busy).
- Frees (resolve or flush) become allocatable the next cycle only; there is no same-cycle bypass.
- stall_o = dec_valid_i & (need > free) & ~flush_i.
- dec_ready_o = iq_ready_i & ~stall_o & ~flush_i.
- fire = dec_valid_i & dec_ready_o.
- Allocation is combinational within the fire cycle:
  - Branch lanes take free tags in ascending lane order, lowest free index first.
  - The group is all-or-nothing; no partial allocation.
  - Non-branch lanes drive alloc_id_o = 0 with alloc_valid_o = 0.
- On allocation of tag k, registered next edge:
  - busy[k] <= 1.
  - age[k] <= busy (pre-cycle) | tags allocated to lower lanes of the same group.
- Resolve correct (resolve_valid_i & ~resolve_mispredict_i): busy[resolve_id_i] <= 0; no other effect.
- Resolve mispredict:
  - Kill set K = {resolve_id_i} ∪ {j : busy[j] & age[j][resolve_id_i]}.
  - busy &= ~K; squash_mask_o <= K next cycle.
  - Allocation is suppressed that cycle: dec_ready_o = 0 when resolve_valid_i & resolve_mispredict_i.
- flush_i has highest priority:
  - busy <= 0; squash_mask_o <= old busy; allocation and resolve ignored.
- Resolve of a non-busy tag is ignored; an SVA flags it.
- Simultaneous correct resolve + allocation: both apply. The resolved tag is not reused in the same cycle.
- inflight_cnt_o = popcount(busy), registered view of the current state. MAX_BRANCH_IF occupied is reported as full count, with no wrap.
- Reset (async): busy=0, age=0, squash_mask_o=0, inflight_cnt_o=0. Combinational outputs follow from the reset state: dec_ready_o=iq_ready_i, stall_o=0 (DECODE_WIDTH ≤ MAX_BRANCH_IF).
- Reset mid-operation drops all tags with no squash pulse.

Optional Feature:
- Macro: BRANCH_TRACKER_STATS_EN.
- With macro defined, adds three outputs, each saturating, zero on reset, and not cleared by flush:
  - stat_stall_cycles_o (32-bit): increments each cycle stall_o=1.
  - stat_peak_inflight_o (ID_BITS+1): running maximum of inflight_cnt_o.
  - stat_mispredicts_o (32-bit): counts mispredict resolves.
- Without the macro, these ports and their registers do not exist.

Test Plan (DECODE_WIDTH=2, MAX_BRANCH_IF=4):
- Reset, then group mask=2'b11, iq_ready_i=1 -> dec_ready_o=1, alloc_id lane0=0, lane1=1, next cycle inflight_cnt_o=2.
- Occupy 3 tags, present mask=2'b11 -> stall_o=1, dec_ready_o=0, no busy change. Correct-resolve tag 0 in the same cycle -> still stalled that cycle; group accepted next cycle with lane0=tag 0 (lowest free index), lane1=tag 3.
- Allocate tags 0,1,2,3 in order, mispredict-resolve tag 1 -> squash_mask_o=4'b1110 next cycle, inflight_cnt_o=1.
- flush_i with 3 tags busy plus a simultaneous valid group -> dec_ready_o=0, squash_mask_o=old busy, inflight_cnt_o=0.
- Correct resolve and mask=2'b01 group in the same cycle with 4 tags busy -> stall_o=1 that cycle, accepted the following cycle reusing the freed tag.
- rst_n asserted mid-stream with 4 tags busy -> all outputs at reset values immediately, no squash pulse after release.
